fizz_buzz_decoder: RTL and testbench

FIZZ_BUZZ_DECODER -- requirements
Module: fizz_buzz_decoder

---
 rtl/fizz_buzz_decoder_if.sv | 45 ++++
 rtl/fizz_buzz_decoder.sv | 139 +++++++++++++
 tb/tb_fizz_buzz_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fizz_buzz_decoder_if.sv
// ---------------------------------------------------------------------------
// fizz_buzz_decoder_if
// Purpose : Bundles the beat inputs and decoded outputs of fizz_buzz_decoder.
// Params  : MAX_CYCLES - count period; sets the width of count.
// Signals : in_valid, fizz, buzz, fizzbuzz (beat in, master -> slave)
//           count, count_valid, locked, err (decoded out, slave -> master)
//           err_count (only when FIZZ_BUZZ_DECODER_ERRCNT_EN is defined)
// Modports: master - beat source / observer; slave - the decoder.
// Handshake: in_valid qualifies one beat per cycle. There is no ready; the
//           decoder accepts every valid beat, and the flags are ignored
//           whenever in_valid is low.
// ---------------------------------------------------------------------------
interface fizz_buzz_decoder_if #(
    parameter int MAX_CYCLES = 15
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic          in_valid;
    logic          fizz;
    logic          buzz;
    logic          fizzbuzz;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          locked;
    logic          err;
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    modport master (
        output in_valid, fizz, buzz, fizzbuzz,
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
        input  err_count,
`endif
        input  count, count_valid, locked, err
    );

    modport slave (
        input  in_valid, fizz, buzz, fizzbuzz,
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
        output err_count,
`endif
        output count, count_valid, locked, err
    );
endinterface

// File: rtl/fizz_buzz_decoder.sv
// ---------------------------------------------------------------------------
// fizz_buzz_decoder
// Purpose : Recovers the running count of a fizz/buzz/fizzbuzz flag stream.
//           HUNT waits for a lone fizzbuzz beat, which pins the position to
//           MAX_CYCLES; LOCKED advances the position on every beat, checks
//           the received flags against the flags that position should
//           produce, and drops back to HUNT after LOSS_THRESH consecutive
//           mismatches.
// Params  : MAX_CYCLES (must equal FIZZ*BUZZ), FIZZ, BUZZ (>= 2, coprime),
//           LOSS_THRESH (1..7).
// Ports   : clk         - clock, rising edge
//           reset       - asynchronous, active-high
//           bus         - fizz_buzz_decoder_if.slave (beat in, decode out)
//           o_dbg_state - current FSM state (0 = HUNT, 1 = LOCKED)
// Macro   : FIZZ_BUZZ_DECODER_ERRCNT_EN adds the 8-bit saturating err_count.
// ---------------------------------------------------------------------------
module fizz_buzz_decoder #(
    parameter int MAX_CYCLES  = 15,
    parameter int FIZZ        = 3,
    parameter int BUZZ        = 5,
    parameter int LOSS_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fizz_buzz_decoder_if.slave     bus,
    output logic                   o_dbg_state
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MAX_W  = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] FIZZ_W = CW'(FIZZ);
    localparam logic [CW-1:0] BUZZ_W = CW'(BUZZ);
    localparam logic [3:0]    LOSS_W = 4'(LOSS_THRESH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_pos;
    logic [2:0]    r_miss;
    logic [CW-1:0] r_count;
    logic          r_count_valid;
    logic          r_err;
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
    logic [7:0]    r_err_count;
`endif

    logic [CW-1:0] w_next_pos;
    logic          w_div_fizz;
    logic          w_div_buzz;
    logic          w_exp_fizzbuzz;
    logic          w_exp_fizz;
    logic          w_exp_buzz;
    logic          w_match;
    logic          w_sync_beat;
    logic [3:0]    w_miss_inc;

    // Position the current beat represents once locked; wraps MAX -> 1.
    assign w_next_pos = (r_pos == MAX_W) ? CW'(1) : (r_pos + CW'(1));

    // Divisors are constants, so these reduce to small fixed comparators.
    assign w_div_fizz     = ((w_next_pos % FIZZ_W) == '0);
    assign w_div_buzz     = ((w_next_pos % BUZZ_W) == '0);
    assign w_exp_fizzbuzz = w_div_fizz & w_div_buzz;
    assign w_exp_fizz     = w_div_fizz & ~w_exp_fizzbuzz;
    assign w_exp_buzz     = w_div_buzz & ~w_exp_fizzbuzz;

    // All three flags must agree; more than one flag set never matches.
    assign w_match = (bus.fizz     == w_exp_fizz) &&
                     (bus.buzz     == w_exp_buzz) &&
                     (bus.fizzbuzz == w_exp_fizzbuzz);

    assign w_sync_beat = bus.fizzbuzz & ~bus.fizz & ~bus.buzz;
    assign w_miss_inc  = {1'b0, r_miss} + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_pos         <= '0;
            r_miss        <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_err         <= 1'b0;
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
            r_err_count   <= '0;
`endif
        end else begin
            // Pulses default low; only a valid beat can raise them.
            r_count_valid <= 1'b0;
            r_err         <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_sync_beat) begin
                            r_state <= LOCKED;
                            r_pos   <= MAX_W;
                            r_miss  <= '0;
                        end
                    end
                    LOCKED: begin
                        // Position advances on every beat, matched or not.
                        r_pos <= w_next_pos;
                        if (w_match) begin
                            r_count       <= w_next_pos;
                            r_count_valid <= 1'b1;
                            r_miss        <= '0;
                        end else begin
                            r_err <= 1'b1;
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
`endif
                            if (w_miss_inc >= LOSS_W) begin
                                r_state <= HUNT;
                                r_miss  <= '0;
                            end else begin
                                r_miss <= w_miss_inc[2:0];
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign bus.count       = r_count;
    assign bus.count_valid = r_count_valid;
    assign bus.err         = r_err;
    assign bus.locked      = (r_state == LOCKED);
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
    assign bus.err_count   = r_err_count;
`endif
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fizz_buzz_decoder.sv
// ---------------------------------------------------------------------------
// tb_fizz_buzz_decoder
// Drives fizz/buzz/fizzbuzz beat streams into fizz_buzz_decoder and checks
// every output after each clock edge against a behavioural model that works
// on plain integer counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fizz_buzz_decoder;
    localparam int MAXC = 15;
    localparam int FZ   = 3;
    localparam int BZ   = 5;
    localparam int LOSS = 2;
    localparam int CW   = $clog2(MAXC + 1);

    logic clk;
    logic reset;
    logic dbg_state;

    fizz_buzz_decoder_if #(.MAX_CYCLES(MAXC)) bus ();

    fizz_buzz_decoder #(
        .MAX_CYCLES (MAXC),
        .FIZZ       (FZ),
        .BUZZ       (BZ),
        .LOSS_THRESH(LOSS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // ---------------- reference model ----------------
    bit m_locked;
    int m_pos;
    int m_miss;
    int m_count;
    bit m_cv;
    bit m_err;
    int m_errcnt;
    int s;              // last value sent in the nominal count stream

    // {fizzbuzz, buzz, fizz} that value c should carry
    function automatic logic [2:0] flags_for(int c);
        bit fb;
        bit f;
        bit b;
        fb = (c % FZ == 0) && (c % BZ == 0);
        f  = (c % FZ == 0) && !fb;
        b  = (c % BZ == 0) && !fb;
        return {fb, b, f};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_miss = 0; m_count = 0;
        m_cv = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_beat(bit v, logic [2:0] fl);
        m_cv  = 0;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (fl == 3'b100) begin
                    m_locked = 1;
                    m_pos    = MAXC;
                    m_miss   = 0;
                end
            end else begin
                m_pos = (m_pos % MAXC) + 1;
                if (fl == flags_for(m_pos)) begin
                    m_count = m_pos;
                    m_cv    = 1;
                    m_miss  = 0;
                end else begin
                    m_err  = 1;
                    m_miss = m_miss + 1;
                    if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
                    if (m_miss >= LOSS) begin
                        m_locked = 0;
                        m_miss   = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of input, waits past the edge, advances the model.
    task automatic drive_beat(bit v, logic [2:0] fl);
        bus.in_valid = v;
        bus.fizz     = fl[0];
        bus.buzz     = fl[1];
        bus.fizzbuzz = fl[2];
        @(posedge clk);
        #1;
        model_beat(v, fl);
    endtask

    task automatic send_value(int c);
        s = c;
        drive_beat(1'b1, flags_for(c));
    endtask

    // Sends clean stream values up to MAXC so the model/DUT end up locked
    // at the top of the period.
    task automatic sync_to_top();
        do send_value((s % MAXC) + 1); while (s != MAXC);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 0; bus.fizz = 0; bus.buzz = 0; bus.fizzbuzz = 0;
        model_reset();
        s = 0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.count !== CW'(0) || bus.count_valid !== 1'b0 ||
            bus.locked !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: count=%0d cv=%b locked=%b err=%b required 0 0 0 0",
                     bus.count, bus.count_valid, bus.locked, bus.err);
        end
        reset = 1'b0;
    endtask

    task automatic test_acquire();
        for (int c = 1; c <= MAXC; c++) begin
            send_value(c);
            tests_run++;
            if (bus.locked !== m_locked || bus.err !== 1'b0 || bus.count_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL acquire beat %0d: locked=%b err=%b cv=%b required %b 0 0",
                         c, bus.locked, bus.err, bus.count_valid, m_locked);
            end
        end
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL acquire_lock: locked=%b required 1", bus.locked);
        end
    endtask

    task automatic test_clean_run();
        sync_to_top();
        for (int i = 1; i <= 2 * MAXC; i++) begin
            send_value((s % MAXC) + 1);
            tests_run++;
            if (bus.count_valid !== 1'b1 || bus.count !== CW'(s) || bus.err !== 1'b0) begin
                tests_failed++;
                $display("FAIL clean_run beat %0d: cv=%b count=%0d err=%b required 1 %0d 0",
                         i, bus.count_valid, bus.count, bus.err, s);
            end
        end
    endtask

    task automatic test_single_error();
        logic [2:0] fl;
        sync_to_top();
        for (int c = 1; c <= 7; c++) begin
            fl = flags_for(c);
            if (c == 6) fl[0] = 1'b0;     // drop the fizz flag on beat 6
            s = c;
            drive_beat(1'b1, fl);
            tests_run++;
            if (bus.err !== m_err || bus.count_valid !== m_cv ||
                bus.count !== CW'(m_count) || bus.locked !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_error beat %0d: err=%b cv=%b count=%0d locked=%b required %b %b %0d 1",
                         c, bus.err, bus.count_valid, bus.count, bus.locked, m_err, m_cv, m_count);
            end
        end
    endtask

    task automatic test_loss_relock();
        logic [2:0] fl;
        sync_to_top();
        for (int c = 1; c <= MAXC; c++) begin
            fl = flags_for(c);
            if (c == 3 || c == 4) fl = fl ^ 3'b001;
            s = c;
            drive_beat(1'b1, fl);
            tests_run++;
            if (bus.err !== m_err || bus.locked !== m_locked || bus.count_valid !== m_cv) begin
                tests_failed++;
                $display("FAIL loss_relock beat %0d: err=%b locked=%b cv=%b required %b %b %b",
                         c, bus.err, bus.locked, bus.count_valid, m_err, m_locked, m_cv);
            end
            if (c == 4) begin
                tests_run++;
                if (bus.locked !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL loss_drop: locked=%b required 0", bus.locked);
                end
            end
        end
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL loss_relock_final: locked=%b required 1", bus.locked);
        end
    endtask

    task automatic test_idle_gap();
        sync_to_top();
        for (int c = 1; c <= 8; c++) send_value(c);
        for (int i = 0; i < 10; i++) begin
            drive_beat(1'b0, 3'($urandom_range(0, 7)));
            tests_run++;
            if (bus.count !== CW'(8) || bus.count_valid !== 1'b0 || bus.err !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_gap cycle %0d: count=%0d cv=%b err=%b required 8 0 0",
                         i, bus.count, bus.count_valid, bus.err);
            end
        end
        send_value(9);
        tests_run++;
        if (bus.count !== CW'(9) || bus.count_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_gap_resume: count=%0d cv=%b required 9 1", bus.count, bus.count_valid);
        end
    endtask

    task automatic test_random();
        bit v;
        logic [2:0] fl;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                s  = (s % MAXC) + 1;
                fl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : flags_for(s);
            end else begin
                fl = 3'($urandom_range(0, 7));
            end
            drive_beat(v, fl);
            tests_run++;
            if (bus.count !== CW'(m_count) || bus.count_valid !== m_cv ||
                bus.err !== m_err || bus.locked !== m_locked ||
                (bus.err === 1'b1 && bus.count_valid === 1'b1)) begin
                tests_failed++;
                $display("FAIL random cycle %0d: count=%0d cv=%b err=%b locked=%b required %0d %b %b %b",
                         i, bus.count, bus.count_valid, bus.err, bus.locked,
                         m_count, m_cv, m_err, m_locked);
            end
        end
    endtask

    task automatic test_reset_midlock();
        sync_to_top();
        send_value(1);
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if (bus.count !== CW'(0) || bus.count_valid !== 1'b0 ||
            bus.locked !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midlock_async: count=%0d cv=%b locked=%b err=%b required 0 0 0 0",
                     bus.count, bus.count_valid, bus.locked, bus.err);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        // Stream continues from 2; nothing may lock before a fresh fizzbuzz.
        for (int c = 2; c <= 6; c++) begin
            send_value(c);
            tests_run++;
            if (bus.locked !== 1'b0 || bus.count_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_midlock_relock beat %0d: locked=%b cv=%b required 0 0",
                         c, bus.locked, bus.count_valid);
            end
        end
    endtask

`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
    task automatic test_err_saturate();
        for (int i = 0; i < 150; i++) begin
            drive_beat(1'b1, 3'b100);
            drive_beat(1'b1, 3'b111);
            drive_beat(1'b1, 3'b111);
        end
        tests_run++;
        if (bus.err_count !== 8'(m_errcnt) || m_errcnt != 255) begin
            tests_failed++;
            $display("FAIL err_count_saturate: got %0d required 255", bus.err_count);
        end
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if (bus.err_count !== 8'd0 || bus.locked !== 1'b0 || bus.count !== CW'(0)) begin
            tests_failed++;
            $display("FAIL err_count_reset: err_count=%0d locked=%b count=%0d required 0 0 0",
                     bus.err_count, bus.locked, bus.count);
        end
        model_reset();
        s = 0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_acquire();
        test_clean_run();
        test_single_error();
        test_loss_relock();
        test_idle_gap();
        test_random();
        test_reset_midlock();
`ifdef FIZZ_BUZZ_DECODER_ERRCNT_EN
        test_err_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case a task ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
